// File: rtl/midi_msg_parser_if.sv
// Decoded MIDI event stream between the parser FIFO head and its consumer.
// Valid/ready handshake; the head fields stay put while valid is low.
interface midi_msg_parser_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_type;
  logic [3:0] evt_chan;
  logic [6:0] evt_d1;
  logic [6:0] evt_d2;

  modport master (
    output evt_valid, evt_type, evt_chan, evt_d1, evt_d2,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_type, evt_chan, evt_d1, evt_d2,
    output evt_ready
  );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte stream to channel-voice event parser with running status, channel filter
// and a first-word-fall-through event FIFO.
module midi_msg_parser #(
  parameter int unsigned FIFO_DEPTH          = 4,
  parameter bit          NOTE_ON_ZERO_AS_OFF = 1'b1
) (
  input  logic                     CLOCK_25,
  input  logic                     reset,
  input  logic                     byteready,
  input  logic [7:0]               midi_in_data,
  input  logic                     omni,
  input  logic [3:0]               ch_sel,
  midi_msg_parser_if.master        evt,
  output logic                     overflow,
  output logic                     status_valid
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 21;

  typedef enum logic [2:0] {StIdle, StSysex, StSkip, StD1, StD2} state_e;

  logic [2:0]    sync_q;
  logic          stb;
  state_e        state_q, state_d;
  logic [6:0]    stat_q, stat_d;
  logic [6:0]    d1_q, d1_d;
  logic          msg_done;
  logic [6:0]    msg_d1, msg_d2;
  logic [2:0]    msg_type;
  logic          push;
  logic [EW-1:0] wdata;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [EW-1:0] head_q, head_d;
  logic          full, empty, pop, wr_en;
  logic          overflow_q, overflow_d;

  // Two synchronizer flops, the third only remembers the previous level for edge detect.
  always_ff @(posedge CLOCK_25) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], byteready};
  end
  assign stb = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    d1_d     = d1_q;
    msg_done = 1'b0;
    msg_d1   = d1_q;
    msg_d2   = '0;
    if (stb) begin
      if (midi_in_data == 8'hFF) begin
        state_d = StIdle;
      end else if (midi_in_data >= 8'hF8) begin
        state_d = state_q;
      end else if (midi_in_data == 8'hF0) begin
        state_d = StSysex;
      end else if (midi_in_data == 8'hF7) begin
        if (state_q == StSysex) state_d = StIdle;
      end else if (midi_in_data >= 8'hF1) begin
        state_d = StSkip;
      end else if (midi_in_data[7]) begin
        stat_d  = midi_in_data[6:0];
        state_d = StD1;
      end else begin
        case (state_q)
          StD1: begin
            d1_d = midi_in_data[6:0];
            // Program change and channel aftertouch carry a single data byte.
            if (stat_q[6:4] == 3'd4 || stat_q[6:4] == 3'd5) begin
              msg_done = 1'b1;
              msg_d1   = midi_in_data[6:0];
            end else begin
              state_d = StD2;
            end
          end
          StD2: begin
            msg_done = 1'b1;
            msg_d2   = midi_in_data[6:0];
            state_d  = StD1;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  assign status_valid = (state_q == StD1) || (state_q == StD2);

  always_comb begin
    msg_type = stat_q[6:4];
    if (NOTE_ON_ZERO_AS_OFF && msg_type == 3'd1 && msg_d2 == 7'd0) msg_type = 3'd0;
  end

  assign push  = msg_done & (omni | (stat_q[3:0] == ch_sel));
  assign wdata = {msg_type, stat_q[3:0], msg_d1, msg_d2};

  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop        = ~empty & evt.evt_ready;
  assign wr_en      = push & (~full | pop);
  assign wr_d       = wr_q + PW'(wr_en);
  assign rd_d       = rd_q + PW'(pop);
  assign overflow_d = overflow_q | (push & full & ~pop);

  // Head register tracks the entry at the next read pointer so it holds when the FIFO drains.
  always_comb begin
    head_d = head_q;
    if (wr_d != rd_d) begin
      if (rd_d == wr_q) head_d = wdata;
      else              head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q    <= StIdle;
      stat_q     <= '0;
      d1_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      d1_q       <= d1_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt.evt_valid = ~empty;
  assign {evt.evt_type, evt.evt_chan, evt.evt_d1, evt.evt_d2} = head_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_midi_msg_parser.sv
// Randomized bench for midi_msg_parser against a message-level reference model.
module tb_midi_msg_parser;
  localparam int unsigned DEPTH = 4;

  logic       CLOCK_25 = 1'b0;
  logic       reset = 1'b1;
  logic       byteready = 1'b0;
  logic [7:0] midi_in_data = 8'h00;
  logic       omni = 1'b1;
  logic [3:0] ch_sel = 4'h0;
  logic       overflow;
  logic       status_valid;

  midi_msg_parser_if evt_if ();

  midi_msg_parser #(
    .FIFO_DEPTH          (DEPTH),
    .NOTE_ON_ZERO_AS_OFF (1'b1)
  ) dut (
    .CLOCK_25     (CLOCK_25),
    .reset        (reset),
    .byteready    (byteready),
    .midi_in_data (midi_in_data),
    .omni         (omni),
    .ch_sel       (ch_sel),
    .evt          (evt_if),
    .overflow     (overflow),
    .status_valid (status_valid)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int          checks = 0;
  int          errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] shown = '0;
  bit          m_ovf = 1'b0;
  bit          have_status = 1'b0;
  logic [7:0]  m_status = 8'h00;
  logic [6:0]  m_data[$];
  int          age = -1;
  logic [7:0]  cur_byte = 8'h00;
  int          ready_mode = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Message-level view: a held status plus the data bytes collected for it.
  function automatic void model_parse(input logic [7:0] b, output bit emit,
                                      output logic [20:0] ev);
    int         need;
    logic [2:0] typ;
    logic [6:0] d1, d2;
    emit = 1'b0;
    ev   = '0;
    if (b == 8'hFF || b == 8'hF0 || (b >= 8'hF1 && b <= 8'hF6)) begin
      have_status = 1'b0;
      m_data.delete();
    end else if (b >= 8'hF7) begin
      // realtime bytes and a stray end-of-exclusive leave the message untouched
    end else if (b[7]) begin
      have_status = 1'b1;
      m_status    = b;
      m_data.delete();
    end else if (have_status) begin
      m_data.push_back(b[6:0]);
      need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
      if (m_data.size() == need) begin
        typ = m_status[6:4];
        d1  = m_data[0];
        d2  = (need == 2) ? m_data[1] : 7'd0;
        if (typ == 3'd1 && d2 == 7'd0) typ = 3'd0;
        ev   = {typ, m_status[3:0], d1, d2};
        emit = omni || (m_status[3:0] == ch_sel);
        m_data.delete();
      end
    end
  endfunction

  // Model the coming rising edge with the inputs now applied, then check at the falling edge.
  task automatic tick();
    bit          emit;
    bit          pop;
    logic [20:0] ev;
    logic [20:0] exp_head;
    if (reset) begin
      exp_q.delete();
      m_data.delete();
      m_ovf       = 1'b0;
      have_status = 1'b0;
      age         = -1;
      shown       = '0;
    end else begin
      emit = 1'b0;
      ev   = '0;
      pop  = (exp_q.size() > 0) && (evt_if.evt_ready == 1'b1);
      if (age >= 0) begin
        age++;
        if (age == 3) model_parse(cur_byte, emit, ev);
      end
      if (pop) void'(exp_q.pop_front());
      if (emit) begin
        if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
        else                       exp_q.push_back(ev);
      end
    end
    @(negedge CLOCK_25);
    exp_head = (exp_q.size() > 0) ? exp_q[0] : shown;
    shown    = exp_head;
    check_eq("evt_valid", 32'(evt_if.evt_valid), 32'(exp_q.size() > 0));
    check_eq("head", 32'({evt_if.evt_type, evt_if.evt_chan, evt_if.evt_d1, evt_if.evt_d2}),
             32'(exp_head));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("status_valid", 32'(status_valid), 32'(have_status));
    case (ready_mode)
      0:       evt_if.evt_ready = 1'b0;
      1:       evt_if.evt_ready = 1'b1;
      2:       evt_if.evt_ready = 1'($urandom_range(0, 1));
      3:       evt_if.evt_ready = (age == 2);
      default: evt_if.evt_ready = 1'b0;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    midi_in_data = b;
    cur_byte     = b;
    byteready    = 1'b1;
    age          = 0;
    repeat (hold) tick();
    byteready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 4);
    send_byte(b, 4);
    send_byte(c, 4);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [7:0] rb;
  int         r;

  initial begin
    evt_if.evt_ready = 1'b0;
    ready_mode = 1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    check_eq("rst_status", 32'(status_valid), 32'd0);
    tick();

    // Single note-on, then running status with zero-velocity conversion.
    send3(8'h90, 8'h3C, 8'h64);
    send_byte(8'h91, 4);
    send3(8'h40, 8'h7F, 8'h41);
    send_byte(8'h00, 4);
    check_eq("run_status", 32'(status_valid), 32'd1);

    // One-data-byte messages and pitch bend.
    send3(8'hC2, 8'h05, 8'h07);
    send3(8'hE0, 8'h00, 8'h40);

    // Interleaved realtime, then sysex kills running status.
    send3(8'h90, 8'hF8, 8'h3C);
    send_byte(8'hFE, 20);
    send_byte(8'h64, 4);
    send_byte(8'hF0, 4);
    check_eq("sysex_status", 32'(status_valid), 32'd0);
    send3(8'h01, 8'h02, 8'hF7);
    send_byte(8'h3C, 4);
    send_byte(8'h64, 4);

    // Back-pressure: four fill the FIFO, a fifth lands on a same-cycle pop.
    ready_mode = 0;
    for (int k = 1; k <= 4; k++) send3(8'h90, 8'(k), 8'h40);
    check_eq("full_no_ovf", 32'(overflow), 32'd0);
    send_byte(8'h90, 4);
    send_byte(8'h05, 4);
    ready_mode = 3;
    send_byte(8'h40, 4);
    ready_mode = 0;
    check_eq("push_pop_ovf", 32'(overflow), 32'd0);
    send3(8'h90, 8'h06, 8'h40);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    ready_mode = 1;
    repeat (8) tick();
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Channel filter, then reset in the middle of a message.
    omni   = 1'b0;
    ch_sel = 4'h3;
    send3(8'h92, 8'h10, 8'h20);
    send3(8'h93, 8'h10, 8'h20);
    send_byte(8'h93, 4);
    pulse_reset();
    send_byte(8'h10, 4);
    check_eq("rst_mid_status", 32'(status_valid), 32'd0);
    check_eq("rst_mid_valid", 32'(evt_if.evt_valid), 32'd0);
    check_eq("rst_mid_ovf", 32'(overflow), 32'd0);

    // Random byte stream with random back-pressure and filter changes.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      if ($urandom_range(0, 19) == 0) begin
        omni   = 1'($urandom_range(0, 1));
        ch_sel = 4'($urandom_range(0, 3));
      end
      if (i % 50 == 0) ready_mode = (ready_mode == 2) ? 0 : 2;
      r = $urandom_range(0, 99);
      if (r < 55)      rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
      else if (r < 85) rb = {1'b1, 3'($urandom_range(0, 6)), 4'($urandom_range(0, 3))};
      else             rb = 8'($urandom_range(8'hF0, 8'hFF));
      send_byte(rb, ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(3, 8));
    end

    ready_mode = 1;
    repeat (10) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Sits directly downstream of the MIDI UART receiver.
- Takes each received MIDI byte (UART byte strobe plus data) and tracks running status itself.
- Assembles complete channel-voice messages and applies a channel filter.
- Queues decoded events in a small first-word-fall-through FIFO for the voice/controller logic to pop via valid/ready.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
NOTE_ON_ZERO_AS_OFF, 1, when 1 a note-on with velocity 0 is emitted as a note-off.

Ports:
CLOCK_25  in  1  system clock, 25 MHz.
reset  in  1  synchronous, active-high reset.
byteready  in  1  UART byte-ready level; asynchronous to CLOCK_25, high for about one MIDI bit time.
midi_in_data  in  8  received byte; stable while byteready is high.
omni  in  1  1 = accept all channels.
ch_sel  in  4  accepted channel when omni=0.
evt_valid  out  1  FIFO head holds an event.
evt_ready  in  1  consumer pops the head when evt_valid & evt_ready.
evt_type  out  3  status[6:4]: 0 note-off, 1 note-on, 2 poly AT, 3 CC, 4 program, 5 channel AT, 6 pitch bend.
evt_chan  out  4  status[3:0].
evt_d1  out  7  first data byte.
evt_d2  out  7  second data byte; 0 for one-data-byte messages.
overflow  out  1  sticky; an event was dropped because the FIFO was full.
status_valid  out  1  running status is currently held.

Behaviour:
Reset (synchronous, active-high; applies at any point, including mid-message):
- evt_valid=0, overflow=0, status_valid=0.
- evt_type, evt_chan, evt_d1, evt_d2 = 0.
- FIFO emptied; state=IDLE; synchronizer flops cleared.

Byte strobe:
- byteready passes through 2 flops, then a rising-edge detect produces a one-cycle strobe (stb).
- midi_in_data is registered in the stb cycle; it has been stable for at least 2 cycles by then.
- A byteready level lasting many cycles yields exactly one stb.

Byte classification on stb, in priority order:
- F8-FE (realtime): ignored. No change to state or data count.
- FF (system reset): state=IDLE, running status cleared.
- F0: state=SYSEX, running status cleared.
- F7: state=IDLE if in SYSEX; otherwise ignored.
- F1-F6: state=SKIP, running status cleared.
- 80-EF: latch status.
  - Cx or Dx: need=1. All others: need=2.
  - state=D1, status_valid=1.
- 00-7F (data byte), by state:
  - IDLE, SYSEX, SKIP: byte discarded.
  - D1: latch d1. If need=1, push the event (d2=0) and stay in D1. Otherwise go to D2.
  - D2: latch d2, push the event, return to D1 (running status retained).

Push rules:
- Push only if omni=1 or status[3:0]==ch_sel. A filtered message is silently discarded and parsing continues.
- If NOTE_ON_ZERO_AS_OFF=1 and type=1 and d2=0, evt_type is set to 0 with d2 kept at 0.

FIFO:
- First-word-fall-through; outputs are driven from the head entry.
- Latency: the stb that completes a message is cycle N. With the FIFO empty, evt_valid=1 in cycle N+1 with the head fields valid.
- Pop on evt_valid & evt_ready. The next entry appears in the following cycle.
- Full with no pop in the same cycle: push is dropped and overflow is set. overflow is cleared only by reset.
- Full with a pop in the same cycle: push is accepted and overflow is unchanged.
- Empty: evt_ready is ignored.
- Pointers are log2(FIFO_DEPTH) bits with an extra wrap bit, and wrap modulo depth.
- Head fields keep their last value when evt_valid=0.

Test Plan:
1. Send 90 3C 64 with omni=1, evt_ready=1 -> one event: type 1, chan 0, d1 3C, d2 64; evt_valid high 1 cycle after the last stb.
2. Send 91 40 7F 41 00 -> two events: (1,1,40,7F), then (0,1,41,00) via zero-velocity conversion; status_valid stays 1.
3. Send C2 05 07, then E0 00 40 -> events (4,2,05,00), (4,2,07,00), (6,0,00,40).
4. Send 90 F8 3C FE 64, then F0 01 02 F7 3C 64 -> one event (1,0,3C,64); after F0, status_valid=0 and the trailing data produces no event.
5. Hold evt_ready=0 and send 5 complete note-ons with DEPTH=4 -> 4 queued, overflow=1; releasing evt_ready pops the 4 in order. Also: FIFO full, pop and push in the same cycle -> push accepted, overflow unchanged.
6. Set omni=0, ch_sel=3 and send 92 10 20 93 10 20 -> only chan 3 is emitted. Then assert reset between 93 and 10 -> no event, status_valid=0, evt_valid=0.
